// File: rtl/flappy_pixel_renderer.sv
// flappy_pixel_renderer: 640x480@60 VGA renderer for the flappy game state.
// Generates VGA timing from a divided pixel tick, snapshots the game state
// once per frame at (h=0, v=480) and composites bird, coin, pipes and the
// background through a two-stage pipeline (rgb, hs and vs share the latency).
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   bird_y            [9:0] bird bottom edge (world y), [15] rising
//   pipe1..pipe3      [27:20] gap, [19:10] left x, [9:0] gap bottom y
//   coin              [31] valid, [19:10] bottom y, [9:0] left x
//   status            2'b11 two-player, anything else single-player
//   hs, vs            active-low syncs
//   r, g, b           4-bit colour channels
//   frame_tick        one-clk pulse when the snapshot is taken
module flappy_pixel_renderer #(
  parameter int unsigned PIX_DIV   = 4,
  parameter int unsigned BIRD_X    = 40,
  parameter int unsigned BIRD_SIZE = 16,
  parameter int unsigned PIPE_W    = 50,
  parameter int unsigned COIN_SIZE = 16,
  parameter int unsigned RIM       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bird_y,
  input  logic [31:0] pipe1,
  input  logic [31:0] pipe2,
  input  logic [31:0] pipe3,
  input  logic [31:0] coin,
  input  logic [1:0]  status,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        frame_tick
);

  localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned H_VIS    = 640;
  localparam int unsigned H_SYNC_S = 656;
  localparam int unsigned H_SYNC_E = 751;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_VIS    = 480;
  localparam int unsigned V_SYNC_S = 490;
  localparam int unsigned V_SYNC_E = 491;
  localparam int unsigned V_TOTAL  = 525;

  localparam logic [11:0] C_BLANK   = 12'h000;
  localparam logic [11:0] C_BIRD_UP = 12'hFE0;
  localparam logic [11:0] C_BIRD_DN = 12'hFA0;
  localparam logic [11:0] C_COIN    = 12'hFD2;
  localparam logic [11:0] C_RIM     = 12'h171;
  localparam logic [11:0] C_PIPE    = 12'h2A2;
  localparam logic [11:0] C_PIPE_P2 = 12'h2AF;
  localparam logic [11:0] C_SKY     = 12'h4CF;

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h, r_v;
  logic             w_tick, w_snap;

  // Shadow copy of the game state, only the fields rendering needs
  logic [27:0] r_pipe [3];
  logic [9:0]  r_bird_y;
  logic        r_bird_rise;
  logic        r_coin_v;
  logic [9:0]  r_coin_x, r_coin_y;
  logic [1:0]  r_status;
  logic        r_frame_tick;

  logic w_unused;
  assign w_unused = ^{bird_y[14:10], pipe1[31:28], pipe2[31:28], pipe3[31:28], coin[30:20]};

  assign w_tick = (r_div == DIV_W'(PIX_DIV - 1));
  assign w_snap = w_tick && (r_h == 10'd0) && (r_v == 10'(V_VIS));

  // Pixel-tick divider
  always_ff @(posedge clk) begin
    if (!rst)        r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DIV_W'(1);
  end

  // Raster counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (r_h == 10'(H_TOTAL - 1)) begin
        r_h <= '0;
        r_v <= (r_v == 10'(V_TOTAL - 1)) ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  // Once-per-frame snapshot so a frame never tears
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) r_pipe[i] <= '0;
      r_bird_y     <= '0;
      r_bird_rise  <= 1'b0;
      r_coin_v     <= 1'b0;
      r_coin_x     <= '0;
      r_coin_y     <= '0;
      r_status     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_snap;
      if (w_snap) begin
        r_pipe[0]   <= pipe1[27:0];
        r_pipe[1]   <= pipe2[27:0];
        r_pipe[2]   <= pipe3[27:0];
        r_bird_y    <= bird_y[9:0];
        r_bird_rise <= bird_y[15];
        r_coin_v    <= coin[31];
        r_coin_x    <= coin[9:0];
        r_coin_y    <= coin[19:10];
        r_status    <= status;
      end
    end
  end

  // Pipe coverage in 11 bits; wrapped pipes compare against x+1024 so the
  // left part of the pipe sits at "negative" columns. Returns {rim, hit}.
  function automatic logic [1:0] pipe_eval(input logic [27:0] p, input logic [10:0] x,
                                           input logic [10:0] y);
    logic [10:0] px, hi, xe, gy, top;
    logic        wrap, norm, cov, col_rim, body, row_rim;
    px      = {1'b0, p[19:10]};
    wrap    = px >= 11'(1024 - PIPE_W);
    norm    = px <= 11'(H_VIS - 1);
    xe      = wrap ? x + 11'd1024 : x;
    hi      = px + 11'(PIPE_W - 1);
    cov     = (wrap || norm) && (x <= 11'(H_VIS - 1)) && (xe >= px) && (xe <= hi);
    col_rim = (xe < px + 11'(RIM)) || (xe + 11'(RIM) > hi);
    gy      = {1'b0, p[9:0]};
    top     = gy + {3'b000, p[27:20]};
    body    = (y < gy) || (y >= top);
    row_rim = ((y < gy) && (y + 11'(RIM) >= gy)) || ((y >= top) && (y < top + 11'(RIM)));
    return {cov && body && (col_rim || row_rim), cov && body};
  endfunction

  logic [10:0] w_x, w_y;
  logic [1:0]  w_pe [3];
  logic        w_bird, w_coin, w_vis, w_hs, w_vs, w_rim, w_body, w_p2;
  logic        w_sel_found;
  logic [1:0]  w_sel;
  logic [9:0]  w_best;

  assign w_x = {1'b0, r_h};
  assign w_y = 11'(V_VIS - 1) - {1'b0, r_v};

  for (genvar gi = 0; gi < 3; gi++) begin : g_pipe
    assign w_pe[gi] = pipe_eval(r_pipe[gi], w_x, w_y);
  end

  // Two-player pipe: on-screen pipe with the largest x (lowest index on ties)
  always_comb begin
    w_sel_found = 1'b0;
    w_sel       = 2'd0;
    w_best      = 10'd0;
    for (int i = 0; i < 3; i++) begin
      if ((r_pipe[i][19:10] <= 10'(H_VIS - 1)) && (!w_sel_found || (r_pipe[i][19:10] > w_best))) begin
        w_sel_found = 1'b1;
        w_sel       = 2'(i);
        w_best      = r_pipe[i][19:10];
      end
    end
  end

  assign w_rim  = w_pe[0][1] || w_pe[1][1] || w_pe[2][1];
  assign w_body = w_pe[0][0] || w_pe[1][0] || w_pe[2][0];
  assign w_p2   = (r_status == 2'b11) && w_sel_found && w_pe[w_sel][0];

  assign w_bird = (w_x >= 11'(BIRD_X)) && (w_x < 11'(BIRD_X + BIRD_SIZE)) &&
                  (w_y >= {1'b0, r_bird_y}) && (w_y < {1'b0, r_bird_y} + 11'(BIRD_SIZE));
  assign w_coin = r_coin_v &&
                  (w_x >= {1'b0, r_coin_x}) && (w_x < {1'b0, r_coin_x} + 11'(COIN_SIZE)) &&
                  (w_y >= {1'b0, r_coin_y}) && (w_y < {1'b0, r_coin_y} + 11'(COIN_SIZE));
  assign w_vis  = (r_h < 10'(H_VIS)) && (r_v < 10'(V_VIS));
  assign w_hs   = !((r_h >= 10'(H_SYNC_S)) && (r_h <= 10'(H_SYNC_E)));
  assign w_vs   = !((r_v >= 10'(V_SYNC_S)) && (r_v <= 10'(V_SYNC_E)));

  // Stage 1: hit flags and raster qualifiers
  logic r_s1_vis, r_s1_hs, r_s1_vs, r_s1_bird, r_s1_rise, r_s1_coin, r_s1_rim, r_s1_body, r_s1_p2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_vis  <= 1'b0;
      r_s1_hs   <= 1'b1;
      r_s1_vs   <= 1'b1;
      r_s1_bird <= 1'b0;
      r_s1_rise <= 1'b0;
      r_s1_coin <= 1'b0;
      r_s1_rim  <= 1'b0;
      r_s1_body <= 1'b0;
      r_s1_p2   <= 1'b0;
    end else if (w_tick) begin
      r_s1_vis  <= w_vis;
      r_s1_hs   <= w_hs;
      r_s1_vs   <= w_vs;
      r_s1_bird <= w_bird;
      r_s1_rise <= r_bird_rise;
      r_s1_coin <= w_coin;
      r_s1_rim  <= w_rim;
      r_s1_body <= w_body;
      r_s1_p2   <= w_p2;
    end
  end

  // Colour priority
  logic [11:0] w_rgb;
  always_comb begin
    w_rgb = C_BLANK;
    if (!r_s1_vis)      w_rgb = C_BLANK;
    else if (r_s1_bird) w_rgb = r_s1_rise ? C_BIRD_UP : C_BIRD_DN;
    else if (r_s1_coin) w_rgb = C_COIN;
    else if (r_s1_rim)  w_rgb = C_RIM;
    else if (r_s1_p2)   w_rgb = C_PIPE_P2;
    else if (r_s1_body) w_rgb = C_PIPE;
    else                w_rgb = C_SKY;
  end

  // Stage 2: colour and delayed syncs
  logic        r_s2_hs, r_s2_vs;
  logic [11:0] r_s2_rgb;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s2_hs  <= 1'b1;
      r_s2_vs  <= 1'b1;
      r_s2_rgb <= C_BLANK;
    end else if (w_tick) begin
      r_s2_hs  <= r_s1_hs;
      r_s2_vs  <= r_s1_vs;
      r_s2_rgb <= w_rgb;
    end
  end

  assign hs         = r_s2_hs;
  assign vs         = r_s2_vs;
  assign r          = r_s2_rgb[11:8];
  assign g          = r_s2_rgb[7:4];
  assign b          = r_s2_rgb[3:0];
  assign frame_tick = r_frame_tick;

endmodule
